// File: rtl/serv_alu_seq.sv
// Word-level sequencer for the bit-serial serv_alu: accepts a 32-bit operation, streams
// the operands LSB-first W bits per cycle and reassembles the serial result into a word.
module serv_alu_seq #(
   parameter int W = 1
) (
   input  logic          clk,
   input  logic          i_rst_n,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [31:0]   i_rs1,
   input  logic [31:0]   i_op_b,
   input  logic          i_sub,
   input  logic [1:0]    i_bool_op,
   input  logic          i_cmp_eq,
   input  logic          i_cmp_sig,
   input  logic [2:0]    i_rd_sel,
   output logic          o_alu_en,
   output logic          o_alu_cnt0,
   output logic [W-1:0]  o_alu_rs1,
   output logic [W-1:0]  o_alu_op_b,
   output logic          o_alu_sub,
   output logic [1:0]    o_alu_bool_op,
   output logic          o_alu_cmp_eq,
   output logic          o_alu_cmp_sig,
   output logic [2:0]    o_alu_rd_sel,
   input  logic [W-1:0]  i_alu_rd,
   input  logic          i_alu_cmp,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [31:0]   o_rd,
   output logic          o_cmp
);

   localparam int N  = 32 / W;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PREP = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic            pass_q, pass_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     rs1_q, rs1_d;
   logic [31:0]     op_b_q, op_b_d;
   logic [31:0]     rs1_sr_q, rs1_sr_d;
   logic [31:0]     op_b_sr_q, op_b_sr_d;
   logic [31:0]     rd_q, rd_d;
   logic            cmp_q, cmp_d;
   logic            sub_q, sub_d;
   logic [1:0]      bool_op_q, bool_op_d;
   logic            cmp_eq_q, cmp_eq_d;
   logic            cmp_sig_q, cmp_sig_d;
   logic [2:0]      rd_sel_q, rd_sel_d;
   logic [W+31:0]   rd_shift_s;
   logic            last_s;

   assign rd_shift_s = {i_alu_rd, rd_q};
   assign last_s     = (cnt_q == LAST);

   // Next-state logic: handshake, pass sequencing and operand/result shifting
   always_comb begin
      state_d   = state_q;
      pass_d    = pass_q;
      cnt_d     = cnt_q;
      rs1_d     = rs1_q;
      op_b_d    = op_b_q;
      rs1_sr_d  = rs1_sr_q;
      op_b_sr_d = op_b_sr_q;
      rd_d      = rd_q;
      cmp_d     = cmp_q;
      sub_d     = sub_q;
      bool_op_d = bool_op_q;
      cmp_eq_d  = cmp_eq_q;
      cmp_sig_d = cmp_sig_q;
      rd_sel_d  = rd_sel_q;
      case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               rs1_d     = i_rs1;
               op_b_d    = i_op_b;
               rs1_sr_d  = i_rs1;
               op_b_sr_d = i_op_b;
               sub_d     = i_sub;
               bool_op_d = i_bool_op;
               cmp_eq_d  = i_cmp_eq;
               cmp_sig_d = i_cmp_sig;
               rd_sel_d  = i_rd_sel;
               pass_d    = ~i_rd_sel[1];
               state_d   = S_PREP;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_PREP: begin
            rs1_sr_d  = rs1_q;
            op_b_sr_d = op_b_q;
            cnt_d     = '0;
            state_d   = S_RUN;
         end
         S_RUN: begin
            rs1_sr_d  = rs1_sr_q >> W;
            op_b_sr_d = op_b_sr_q >> W;
            rd_d      = rd_shift_s[W+31:W];
            if (last_s) begin
               // The slt result pass must not overwrite the flag from the compare pass
               if (!pass_q || !rd_sel_q[1]) begin
                  cmp_d = i_alu_cmp;
               end else begin
                  cmp_d = cmp_q;
               end
               if (!pass_q) begin
                  pass_d  = 1'b1;
                  state_d = S_PREP;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (i_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         pass_q    <= 1'b0;
         cnt_q     <= '0;
         rs1_q     <= 32'd0;
         op_b_q    <= 32'd0;
         rs1_sr_q  <= 32'd0;
         op_b_sr_q <= 32'd0;
         rd_q      <= 32'd0;
         cmp_q     <= 1'b0;
         sub_q     <= 1'b0;
         bool_op_q <= 2'b00;
         cmp_eq_q  <= 1'b0;
         cmp_sig_q <= 1'b0;
         rd_sel_q  <= 3'b000;
      end else begin
         state_q   <= state_d;
         pass_q    <= pass_d;
         cnt_q     <= cnt_d;
         rs1_q     <= rs1_d;
         op_b_q    <= op_b_d;
         rs1_sr_q  <= rs1_sr_d;
         op_b_sr_q <= op_b_sr_d;
         rd_q      <= rd_d;
         cmp_q     <= cmp_d;
         sub_q     <= sub_d;
         bool_op_q <= bool_op_d;
         cmp_eq_q  <= cmp_eq_d;
         cmp_sig_q <= cmp_sig_d;
         rd_sel_q  <= rd_sel_d;
      end
   end

   assign o_ready       = (state_q == S_IDLE);
   assign o_valid       = (state_q == S_DONE);
   assign o_alu_en      = (state_q == S_RUN);
   assign o_alu_cnt0    = (state_q == S_RUN) && (cnt_q == '0);
   assign o_alu_rs1     = rs1_sr_q[W-1:0];
   assign o_alu_op_b    = op_b_sr_q[W-1:0];
   assign o_alu_sub     = sub_q;
   assign o_alu_bool_op = bool_op_q;
   assign o_alu_cmp_eq  = cmp_eq_q;
   assign o_alu_cmp_sig = cmp_sig_q;
   // Compare pass drives no result select so the ALU only evaluates the compare
   assign o_alu_rd_sel  = pass_q ? rd_sel_q : 3'b000;
   assign o_rd          = rd_q;
   assign o_cmp         = cmp_q;

endmodule
